// File: rtl/text_pkg.sv
// text_pkg: shared grid geometry, glyph codes, walk states and cell indexing for the text grid buffer.
package text_pkg;
  localparam int ROWS = 7;
  localparam int COLS = 20;
  localparam int TOTAL = ROWS * COLS;
  localparam int ROW_W = 4;
  localparam int COL_W = 6;
  localparam int GLYPH_W = 8;
  localparam logic [GLYPH_W-1:0] BLANK_GLYPH = 8'd128;
  localparam logic [GLYPH_W-1:0] CLEAR_CODE = 8'hFF;
  localparam logic [GLYPH_W-1:0] UNKNOWN_GLYPH = 8'd128;
  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL, DRAIN} state_t;
  function automatic logic [7:0] cell_idx(logic [ROW_W-1:0] r, logic [COL_W-1:0] c);
    return 8'(r) * 8'(COLS) + 8'(c);
  endfunction
  function automatic logic in_grid(logic [ROW_W-1:0] r, logic [COL_W-1:0] c);
    return r < ROW_W'(ROWS) && c < COL_W'(COLS);
  endfunction
endpackage

// File: rtl/text_grid_if.sv
// text_grid_if: feeder write/scroll/clear strobes, renderer read port and status flags.
interface text_grid_if;
  import text_pkg::*;
  logic wr_en;
  logic [GLYPH_W-1:0] wr_glyph;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic scroll_req;
  logic clear_req;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic [GLYPH_W-1:0] rd_glyph;
  logic busy;
  logic oob_err;
  logic ovf_err;
  modport master (output wr_en, wr_glyph, wr_row, wr_col, scroll_req, clear_req, rd_row, rd_col,
                  input rd_glyph, busy, oob_err, ovf_err);
  modport slave (input wr_en, wr_glyph, wr_row, wr_col, scroll_req, clear_req, rd_row, rd_col,
                 output rd_glyph, busy, oob_err, ovf_err);
endinterface

// File: rtl/text_grid_ram.sv
// text_grid_ram: glyph cell array with one write port, a combinational scroll-source read and a registered renderer read.
module text_grid_ram
  import text_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic we,
  input  logic [7:0] waddr,
  input  logic [GLYPH_W-1:0] wdata,
  input  logic [7:0] saddr,
  output logic [GLYPH_W-1:0] sdata,
  input  logic [7:0] raddr,
  input  logic rd_ok,
  output logic [GLYPH_W-1:0] rdata
);
  logic [GLYPH_W-1:0] mem [TOTAL];
  assign sdata = mem[saddr];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (reset) rdata <= '0;
    else rdata <= rd_ok ? mem[raddr] : BLANK_GLYPH;
  end
endmodule

// File: rtl/text_grid_buffer.sv
// text_grid_buffer: ROWS x COLS glyph store with multi-cycle clear/scroll walks, one-deep pending slots and sticky error flags.
module text_grid_buffer
  import text_pkg::*;
(
  input logic clock,
  input logic reset,
  text_grid_if.slave bus
);
  state_t state;
  logic [7:0] i, saddr, waddr;
  logic scroll_pend, wr_pend, we, walking, last, wr_ok, pend_ok, rd_ok, oob_hit, ovf_hit;
  logic [GLYPH_W-1:0] pg, sdata, wdata;
  logic [ROW_W-1:0] pr;
  logic [COL_W-1:0] pc;
  assign walking = state == CLEAR || state == SCROLL;
  assign last = i >= 8'(TOTAL - 1);
  assign wr_ok = in_grid(bus.wr_row, bus.wr_col);
  assign pend_ok = in_grid(pr, pc);
  assign rd_ok = in_grid(bus.rd_row, bus.rd_col);
  assign saddr = i < 8'(TOTAL - COLS) ? i + 8'(COLS) : i;
  assign we = walking || (state == DRAIN && pend_ok) ||
              (state == IDLE && bus.wr_en && !bus.clear_req && !bus.scroll_req && wr_ok);
  assign waddr = walking ? i : state == DRAIN ? cell_idx(pr, pc) : cell_idx(bus.wr_row, bus.wr_col);
  assign wdata = state == SCROLL ? (i < 8'(TOTAL - COLS) ? sdata : BLANK_GLYPH) :
                 state == DRAIN ? pg : state == IDLE ? bus.wr_glyph : BLANK_GLYPH;
  assign oob_hit = !rd_ok || (state == DRAIN && !pend_ok) ||
                   (state == IDLE && bus.wr_en && !bus.clear_req && !bus.scroll_req && !wr_ok);
  // a write in DRAIN refills the slot being freed, so only walks can overflow it
  assign ovf_hit = state != IDLE && !bus.clear_req &&
                   ((bus.scroll_req && scroll_pend) || (bus.wr_en && wr_pend && state != DRAIN));
  assign bus.busy = state != IDLE;
  text_grid_ram u_ram (
    .clock(clock), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .saddr(saddr), .sdata(sdata),
    .raddr(cell_idx(bus.rd_row, bus.rd_col)), .rd_ok(rd_ok), .rdata(bus.rd_glyph)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      i <= '0;
      scroll_pend <= 1'b0;
      wr_pend <= 1'b0;
      pg <= '0;
      pr <= '0;
      pc <= '0;
      bus.oob_err <= 1'b0;
      bus.ovf_err <= 1'b0;
    end else begin
      if (oob_hit) bus.oob_err <= 1'b1;
      if (ovf_hit) bus.ovf_err <= 1'b1;
      if (state == IDLE) begin
        if (bus.clear_req || bus.scroll_req) begin
          state <= bus.clear_req ? CLEAR : SCROLL;
          i <= '0;
        end
        if (!bus.clear_req && bus.scroll_req && bus.wr_en) begin
          wr_pend <= 1'b1;
          {pg, pr, pc} <= {bus.wr_glyph, bus.wr_row, bus.wr_col};
        end
      end else if (bus.clear_req) begin
        state <= CLEAR;
        i <= '0;
        scroll_pend <= 1'b0;
        wr_pend <= 1'b0;
      end else begin
        if (bus.wr_en && (!wr_pend || state == DRAIN)) begin
          wr_pend <= 1'b1;
          {pg, pr, pc} <= {bus.wr_glyph, bus.wr_row, bus.wr_col};
        end else if (state == DRAIN) wr_pend <= 1'b0;
        if (bus.scroll_req) scroll_pend <= 1'b1;
        if (walking && !last) i <= i + 8'd1;
        else begin
          i <= '0;
          if (scroll_pend || bus.scroll_req) begin
            state <= SCROLL;
            scroll_pend <= 1'b0;
          end else if ((wr_pend && state != DRAIN) || bus.wr_en) state <= DRAIN;
          else state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_text_grid_buffer.sv
// tb_text_grid_buffer: randomized scoreboard bench with a whole-grid reference model of the text buffer.
module tb_text_grid_buffer;
  logic clock = 0;
  logic reset = 1;
  always #5 clock = ~clock;
  text_grid_if bus();
  text_grid_buffer dut (.clock(clock), .reset(reset), .bus(bus));
  int total = 0, bad = 0;
  int model [140];
  int exp_q [$];
  logic rd_v = 0, rd_v_d = 0;
  int e;
  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  always @(posedge clock) rd_v_d <= rd_v;
  always @(negedge clock) if (rd_v_d) begin
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL rd_glyph: value %0d with nothing expected", bus.rd_glyph);
    end else begin
      e = exp_q.pop_front();
      if (int'(bus.rd_glyph) != e) begin
        bad++;
        $display("FAIL rd_glyph: got %0d expected %0d", bus.rd_glyph, e);
      end
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(bit w, int r, int c, int g, bit s, bit cl);
    bus.wr_en = w; bus.wr_row = 4'(r); bus.wr_col = 6'(c); bus.wr_glyph = 8'(g);
    bus.scroll_req = s; bus.clear_req = cl;
    tick();
    bus.wr_en = 0; bus.scroll_req = 0; bus.clear_req = 0;
  endtask
  task automatic wr(int r, int c, int g);
    drive(1, r, c, g, 0, 0);
    if (r < 7 && c < 20) model[r*20+c] = g;
    chk("busy_on_write", bus.busy, 0);
  endtask
  task automatic rd(int r, int c);
    bus.rd_row = 4'(r); bus.rd_col = 6'(c); rd_v = 1;
    exp_q.push_back((r < 7 && c < 20) ? model[r*20+c] : 128);
    tick();
    rd_v = 0;
  endtask
  task automatic rd_all();
    for (int r = 0; r < 7; r++) for (int c = 0; c < 20; c++) rd(r, c);
  endtask
  task automatic busy_len(string name, int req);
    int n = 0;
    while (bus.busy && n < 1000) begin tick(); n++; end
    chk(name, n, req);
  endtask
  task automatic blank_model();
    for (int k = 0; k < 140; k++) model[k] = 128;
  endtask
  task automatic scroll_model();
    for (int r = 0; r < 7; r++) for (int c = 0; c < 20; c++) model[r*20+c] = (r < 6) ? model[(r+1)*20+c] : 128;
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    chk("rd_glyph_in_reset", bus.rd_glyph, 0);
    chk("busy_in_reset", bus.busy, 1);
    reset = 0;
    busy_len("reset_clear_len", 140);
    chk("oob_after_reset", bus.oob_err, 0);
    chk("ovf_after_reset", bus.ovf_err, 0);
    blank_model();
  endtask
  initial begin
    bus.wr_en = 0; bus.scroll_req = 0; bus.clear_req = 0; bus.wr_glyph = 0;
    bus.wr_row = 0; bus.wr_col = 0; bus.rd_row = 0; bus.rd_col = 0;
    do_reset();
    rd_all();
    wr(0, 0, 10);
    wr(6, 19, 36);
    rd(0, 0);
    rd(6, 19);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(1) == 1) wr($urandom_range(6), $urandom_range(19), $urandom_range(255));
      else rd($urandom_range(6), $urandom_range(19));
    end
    rd_all();
    chk("oob_after_random", bus.oob_err, 0);
    for (int r = 0; r < 7; r++) for (int c = 0; c < 20; c++) wr(r, c, r + 1);
    drive(0, 0, 0, 0, 1, 0);
    busy_len("scroll_len", 140);
    scroll_model();
    rd(0, 7); rd(5, 3); rd(6, 19);
    rd_all();
    drive(1, 6, 0, 5, 1, 0);
    busy_len("scroll_drain_len", 141);
    scroll_model();
    model[120] = 5;
    rd(6, 0); rd(6, 1);
    rd_all();
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 2, 3, 77, 0, 0);
    chk("ovf_one_write", bus.ovf_err, 0);
    drive(1, 4, 5, 88, 0, 0);
    chk("ovf_second_write", bus.ovf_err, 1);
    repeat (47) tick();
    drive(0, 0, 0, 0, 0, 1);
    busy_len("clear_restart_len", 140);
    blank_model();
    rd_all();
    chk("ovf_sticky", bus.ovf_err, 1);
    do_reset();
    for (int k = 0; k < 20; k++) wr($urandom_range(6), $urandom_range(19), $urandom_range(255));
    wr(7, 0, 99);
    chk("oob_bad_write", bus.oob_err, 1);
    rd(3, 20);
    rd(7, 0);
    rd(3, 19);
    rd_all();
    repeat (5) tick();
    chk("oob_sticky", bus.oob_err, 1);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
